// File: rtl/cpu_top.sv
// 16-bit accumulator CPU, multi-cycle FSM over one shared
// synchronous-read/write memory port (8-bit address).
module cpu_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic [7:0]  address,
  output logic [15:0] data_out
);

  typedef enum logic [2:0] {
    IF0 = 3'd0,
    IF1 = 3'd1,
    IF2 = 3'd2,
    EX0 = 3'd3,
    EX1 = 3'd4,
    EX2 = 3'd5,
    HLT = 3'd6
  } state_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHIFTR = 8'h0D;
  localparam logic [7:0] OP_SHIFTL = 8'h0E;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] br_q, br_d;
  logic [15:0] mr_q, mr_d;
  logic [7:0]  mar_q, mar_d;
  logic [15:0] mbr_q, mbr_d;

  logic [15:0] Control_Signals;
  logic [7:0]  opc;
  logic        is_mem;
  logic        is_store;
  logic [31:0] prod;

  assign opc      = ir_q[15:8];
  assign is_store = (opc == OP_STORE);
  assign is_mem   = opc inside {OP_STORE, OP_LOAD, OP_ADD,
                                OP_SUB, OP_MPY, OP_AND, OP_OR};

  assign address  = mar_q;
  assign data_out = mbr_q;

  // IF0 decodes to all-zero so reset leaves the strobes idle.
  always_comb begin
    Control_Signals = '0;
    unique case (state_q)
      IF2: begin
        Control_Signals[0] = 1'b1;
        Control_Signals[1] = 1'b1;
      end
      EX0: begin
        Control_Signals[2]  = is_mem;
        Control_Signals[3]  = is_store;
        Control_Signals[4]  = (opc == OP_JMP) ||
                              ((opc == OP_JMPGEZ) && !acc_q[15]);
        Control_Signals[5]  = (opc == OP_SHIFTL);
        Control_Signals[6]  = (opc == OP_SHIFTR);
        Control_Signals[7]  = (opc == OP_NOT);
        Control_Signals[15] = (opc == OP_HALT);
      end
      EX1: begin
        Control_Signals[11] = is_store;
      end
      EX2: begin
        if (is_mem && !is_store) begin
          Control_Signals[8]  = 1'b1;
          Control_Signals[9]  = (opc == OP_ADD);
          Control_Signals[10] = (opc == OP_SUB);
          Control_Signals[12] = (opc == OP_MPY);
          Control_Signals[13] = (opc == OP_AND);
          Control_Signals[14] = (opc == OP_OR);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF0: state_d = IF1;
      IF1: state_d = IF2;
      IF2: state_d = EX0;
      EX0: begin
        if (Control_Signals[15]) begin
          state_d = HLT;
        end else if (is_mem) begin
          state_d = EX1;
        end else begin
          state_d = IF0;
        end
      end
      EX1: state_d = EX2;
      EX2: state_d = IF0;
      HLT: state_d = HLT;
      default: state_d = IF0;
    endcase
  end

  always_comb begin
    prod = $signed({{16{acc_q[15]}}, acc_q}) *
           $signed({{16{data_in[15]}}, data_in});
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    br_d  = br_q;
    mr_d  = mr_q;
    mar_d = mar_q;
    mbr_d = mbr_q;

    if (state_q == IF0) mar_d = pc_q;
    if (Control_Signals[0]) ir_d = data_in;
    if (Control_Signals[1]) pc_d = pc_q + 8'd1;
    if (Control_Signals[2]) mar_d = ir_q[7:0];
    if (Control_Signals[3]) mbr_d = acc_q;
    if (Control_Signals[4]) pc_d = ir_q[7:0];
    if (Control_Signals[5]) acc_d = acc_q << 1;
    if (Control_Signals[6]) acc_d = {acc_q[15], acc_q[15:1]};
    if (Control_Signals[7]) acc_d = ~acc_q;

    // EX2: operand goes to BR and the ALU result to ACC together.
    if (Control_Signals[8]) begin
      br_d = data_in;
      unique case (1'b1)
        Control_Signals[9]:  acc_d = acc_q + data_in;
        Control_Signals[10]: acc_d = acc_q - data_in;
        Control_Signals[12]: begin
          acc_d = prod[15:0];
          mr_d  = prod[31:16];
        end
        Control_Signals[13]: acc_d = acc_q & data_in;
        Control_Signals[14]: acc_d = acc_q | data_in;
        default:             acc_d = data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF0;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      br_q    <= '0;
      mr_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      br_q    <= br_d;
      mr_q    <= mr_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Bench for cpu_top: memory model, write scoreboard,
// per-opcode vector table and hand-written corner sequences.
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [7:0]  address;
  logic [15:0] data_out;

  logic [15:0] mem [256];
  logic [23:0] wq [$];
  logic [23:0] wexp;
  int          n_err = 0;
  int          n_chk = 0;
  int          n_wr  = 0;

  typedef struct {
    string       nm;
    logic [15:0] va;
    logic [15:0] ins;
    logic [15:0] vb;
    logic [15:0] acc;
    logic [15:0] mr;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs [$];

  cpu_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_in <= mem[address];
    if (dut.Control_Signals[11]) mem[address] = data_out;
  end

  always @(negedge clk) begin
    if (dut.Control_Signals[11]) begin
      n_wr++;
      n_chk++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL write: unexpected addr=%h data=%h",
                 address, data_out);
      end else begin
        wexp = wq.pop_front();
        if ({address, data_out} !== wexp) begin
          n_err++;
          $display("FAIL write: got %h/%h want %h/%h",
                   address, data_out, wexp[23:16], wexp[15:0]);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_cpu();
    @(negedge clk);
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == 3'd6) done = 1'b1;
    end
    check({nm, " halt"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          moved;
    bit          seen;
    int          w0;
    logic [7:0]  a_h;

    vecs.push_back('{"ADD",  16'hFFFF, 16'h0341, 16'h0001,
                     16'h0000, 16'h0000, 8'd3});
    vecs.push_back('{"SUB",  16'h00FF, 16'h0441, 16'h0001,
                     16'h00FE, 16'h0000, 8'd3});
    vecs.push_back('{"MPYN", 16'h0014, 16'h0841, 16'hFFF4,
                     16'hFF10, 16'hFFFF, 8'd3});
    vecs.push_back('{"MPYP", 16'h0100, 16'h0841, 16'h0100,
                     16'h0000, 16'h0001, 8'd3});
    vecs.push_back('{"AND",  16'hFE20, 16'h0A41, 16'h0334,
                     16'h0220, 16'h0000, 8'd3});
    vecs.push_back('{"OR",   16'hF000, 16'h0B41, 16'h000F,
                     16'hF00F, 16'h0000, 8'd3});
    vecs.push_back('{"NOT",  16'h00FF, 16'h0C00, 16'h0000,
                     16'hFF00, 16'h0000, 8'd3});
    vecs.push_back('{"SHL",  16'hFF10, 16'h0E00, 16'h0000,
                     16'hFE20, 16'h0000, 8'd3});
    vecs.push_back('{"SHR",  16'h8002, 16'h0D00, 16'h0000,
                     16'hC001, 16'h0000, 8'd3});
    vecs.push_back('{"JGEZT", 16'h0220, 16'h0504, 16'h0000,
                     16'h0220, 16'h0000, 8'd5});
    vecs.push_back('{"JGEZF", 16'h8000, 16'h0504, 16'h0000,
                     16'h8000, 16'h0000, 8'd3});
    vecs.push_back('{"JMP",  16'h8000, 16'h0604, 16'h0000,
                     16'h8000, 16'h0000, 8'd5});
    vecs.push_back('{"OPFF", 16'h1234, 16'hFF41, 16'h5678,
                     16'h1234, 16'h0000, 8'd3});
    vecs.push_back('{"OP09", 16'h1234, 16'h0941, 16'h5678,
                     16'h1234, 16'h0000, 8'd3});
    vecs.push_back('{"STORE", 16'hABCD, 16'h0141, 16'h0000,
                     16'hABCD, 16'h0000, 8'd3});

    // Main program, reset checks and post-halt quiet bus.
    clear_mem();
    mem[0]     = 16'h0232;
    mem[1]     = 16'h013C;
    mem[2]     = 16'h013D;
    mem[3]     = 16'h0434;
    mem[6]     = 16'h0737;
    mem[8'd50] = 16'h00FF;
    mem[8'd52] = 16'h0001;
    wq.push_back({8'd60, 16'h00FF});
    wq.push_back({8'd61, 16'h00FF});
    @(negedge clk);
    rst_n = 1'b0;
    #20;
    check("rst address", {24'd0, address}, 32'd0);
    check("rst data_out", {16'd0, data_out}, 32'd0);
    check("rst we", {31'd0, dut.Control_Signals[11]}, 32'd0);
    rst_n = 1'b1;
    w0 = n_wr;
    repeat (3) @(posedge clk);
    #1;
    check("first IR", {16'd0, dut.ir_q}, 32'h0232);
    check("first PC", {24'd0, dut.pc_q}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (dut.ir_q == 16'h013C) seen = 1'b1;
    end
    check("reach STORE", {31'd0, seen}, 32'd1);
    check("ACC after LOAD", {16'd0, dut.acc_q}, 32'h00FF);
    run_to_halt("main", 100);
    check("main ACC", {16'd0, dut.acc_q}, 32'h00FE);
    check("main PC", {24'd0, dut.pc_q}, 32'd7);
    check("main writes", n_wr - w0, 32'd2);
    check("mem60", {16'd0, mem[8'd60]}, 32'h00FF);
    check("mem61", {16'd0, mem[8'd61]}, 32'h00FF);
    a_h = address;
    w0 = n_wr;
    moved = 1'b0;
    while ($time < 1000) begin
      @(negedge clk);
      if (address !== a_h) moved = 1'b1;
    end
    check("halt bus quiet", {31'd0, moved}, 32'd0);
    check("halt no writes", n_wr - w0, 32'd0);
    check("halt PC", {24'd0, dut.pc_q}, 32'd7);

    // Per-opcode table: LOAD 40, <op>, HALT; jump target 4 is HALT.
    foreach (vecs[i]) begin
      clear_mem();
      mem[0]     = 16'h0240;
      mem[1]     = vecs[i].ins;
      mem[2]     = 16'h0700;
      mem[4]     = 16'h0700;
      mem[8'h40] = vecs[i].va;
      mem[8'h41] = vecs[i].vb;
      if (vecs[i].ins[15:8] == 8'h01)
        wq.push_back({8'h41, vecs[i].va});
      reset_cpu();
      run_to_halt(vecs[i].nm, 100);
      check({vecs[i].nm, " ACC"}, {16'd0, dut.acc_q},
            {16'd0, vecs[i].acc});
      check({vecs[i].nm, " MR"}, {16'd0, dut.mr_q},
            {16'd0, vecs[i].mr});
      check({vecs[i].nm, " PC"}, {24'd0, dut.pc_q},
            {24'd0, vecs[i].pc});
      check({vecs[i].nm, " wq"}, wq.size(), 32'd0);
    end

    // PC wrap: JMPGEZ 80 / NOT / JMP FF / NOP wraps to 0 / HALT at 1.
    clear_mem();
    mem[0]     = 16'h0580;
    mem[1]     = 16'h0700;
    mem[8'h80] = 16'h0C00;
    mem[8'h81] = 16'h06FF;
    mem[8'hFF] = 16'h0000;
    reset_cpu();
    run_to_halt("wrap", 200);
    check("wrap PC", {24'd0, dut.pc_q}, 32'd2);
    check("wrap ACC", {16'd0, dut.acc_q}, 32'hFFFF);
    check("wrap MAR", {24'd0, address}, 32'd1);

    // Reset during EX1 of a STORE: no write, restart from 0.
    clear_mem();
    mem[0]     = 16'h0240;
    mem[1]     = 16'h0150;
    mem[2]     = 16'h0700;
    mem[8'h40] = 16'h5555;
    reset_cpu();
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (dut.Control_Signals[11]) seen = 1'b1;
    end
    check("reach EX1", {31'd0, seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort we", {31'd0, dut.Control_Signals[11]}, 32'd0);
    check("abort addr", {24'd0, address}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort mem50", {16'd0, mem[8'h50]}, 32'd0);
    wq.push_back({8'h50, 16'h5555});
    rst_n = 1'b1;
    run_to_halt("restart", 100);
    check("restart PC", {24'd0, dut.pc_q}, 32'd3);
    check("restart mem50", {16'd0, mem[8'h50]}, 32'h5555);
    check("restart wq", wq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
